// File: rtl/pipe_hazard_pkg.sv
// Shared encodings and the scoreboard entry layout for the ID-stage hazard unit.
package pipe_hazard_pkg;

    // Forwarding select encodings: 0 reads the register file, k reads stage k-1.
    localparam int SEL_RF         = 0;
    localparam int SEL_STAGE_BASE = 1;

    localparam int ST_EX  = 0;
    localparam int ST_MEM = 1;
    localparam int ST_WB  = 2;

    // rd storage is sized for the widest register file we build; narrower
    // addresses are zero-extended on write and on compare.
    localparam int SB_RA_W = 8;

    typedef struct packed {
        logic               v;
        logic [SB_RA_W-1:0] rd;
        logic               ld;
    } sb_entry_t;

    localparam int SB_ENTRY_W = $bits(sb_entry_t);

endpackage

// File: rtl/hazard_port_match.sv
// Priority search of one ID read port against every in-flight destination.
module hazard_port_match
    import pipe_hazard_pkg::*;
#(
    parameter int RA_W       = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int PC_REG     = 15,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  used,
    input  logic [RA_W-1:0]       rs,
    input  sb_entry_t [DEPTH-1:0] sb,
    output logic [SEL_W-1:0]      sel,
    output logic                  not_ready
);

    logic rs_ok;

    assign rs_ok = used && (rs != RA_W'(PC_REG));

    // Walk oldest to youngest so the youngest matching entry is the last writer.
    always_comb begin
        sel       = SEL_W'(SEL_RF);
        not_ready = 1'b0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (rs_ok && sb[s].v && (sb[s].rd == SB_RA_W'(rs))) begin
                not_ready = sb[s].ld && (s < LOAD_READY);
                sel       = not_ready ? SEL_W'(SEL_RF) : SEL_W'(SEL_STAGE_BASE + s);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// ID-stage hazard/forwarding unit with its own in-flight destination scoreboard.
module pipe_hazard_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter int NUM_PORTS  = 3,
    parameter int RA_W       = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int PC_REG     = 15,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       id_valid,
    input  logic [NUM_PORTS*RA_W-1:0]  id_rs,
    input  logic [NUM_PORTS-1:0]       id_rs_used,
    input  logic [RA_W-1:0]            id_rd,
    input  logic                       id_rf_en,
    input  logic                       id_load,
    input  logic                       branch_taken,
    input  logic                       mem_wait,
    output logic [NUM_PORTS*SEL_W-1:0] fwd_sel,
    output logic                       pc_en,
    output logic                       ifid_le,
    output logic                       nop_insert,
    output logic                       ifid_flush,
    output logic [15:0]                stall_count
);

    sb_entry_t [DEPTH-1:0]            sb;
    sb_entry_t                        push;
    logic [NUM_PORTS-1:0][SEL_W-1:0]  port_sel;
    logic [NUM_PORTS-1:0]             port_not_ready;
    logic                             lu;
    logic                             stall_inc;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        hazard_port_match #(
            .RA_W       (RA_W),
            .DEPTH      (DEPTH),
            .LOAD_READY (LOAD_READY),
            .PC_REG     (PC_REG),
            .SEL_W      (SEL_W)
        ) u_match (
            .used      (id_rs_used[p]),
            .rs        (id_rs[p*RA_W +: RA_W]),
            .sb        (sb),
            .sel       (port_sel[p]),
            .not_ready (port_not_ready[p])
        );
        assign fwd_sel[p*SEL_W +: SEL_W] = port_sel[p];
    end

    assign lu = id_valid && (|port_not_ready);

    // A memory wait beats everything; a taken branch squashes ID, so its stall is moot.
    always_comb begin
        pc_en      = 1'b1;
        ifid_le    = 1'b1;
        nop_insert = 1'b0;
        ifid_flush = 1'b0;
        stall_inc  = 1'b0;
        if (mem_wait) begin
            pc_en   = 1'b0;
            ifid_le = 1'b0;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            nop_insert = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_le    = 1'b0;
            nop_insert = 1'b1;
            stall_inc  = 1'b1;
        end
    end

    always_comb begin
        push.v  = id_valid && id_rf_en && !nop_insert && (id_rd != RA_W'(PC_REG));
        push.rd = SB_RA_W'(id_rd);
        push.ld = id_load;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            sb          <= '0;
            stall_count <= '0;
        end else if (!mem_wait) begin
            for (int s = DEPTH - 1; s > 0; s--) begin
                sb[s] <= sb[s-1];
            end
            sb[ST_EX] <= push;
            if (stall_inc && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule
